// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM period and high-time capture with stuck-input timeout
module pwm_capture #(
   parameter int CNT_BITS    = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                enable_i,
   input  logic                pwm_i,
   output logic [CNT_BITS-1:0] period_o,
   output logic [CNT_BITS-1:0] high_o,
   output logic                valid_o,
   output logic                timeout_o,
   output logic                level_o
);

   // A single flop cannot resolve metastability, so shorter chains are widened to two.
   localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
   localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};
   localparam logic [CNT_BITS-1:0] CNT_MAX = {CNT_BITS{1'b1}};

   typedef enum logic [1:0] {
      IDLE,
      HIGH,
      LOW
   } state_t;

   state_t              state_q;
   state_t              state_d;
   logic [SYNC_N-1:0]   sync_q;
   logic                prev_q;
   logic                s;
   logic                rise;
   logic                fall;
   logic                sat;
   logic [CNT_BITS-1:0] cnt_q;
   logic [CNT_BITS-1:0] cnt_d;
   logic [CNT_BITS-1:0] cnt_inc;
   logic [CNT_BITS-1:0] high_r_q;
   logic [CNT_BITS-1:0] high_r_d;
   logic [CNT_BITS-1:0] period_d;
   logic [CNT_BITS-1:0] high_d;
   logic                valid_d;
   logic                timeout_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_N-2:0], pwm_i};
         prev_q <= s;
      end
   end

   assign s       = sync_q[SYNC_N-1];
   assign level_o = s;
   assign rise    = s & ~prev_q;
   assign fall    = ~s & prev_q;
   assign sat     = (cnt_q == CNT_MAX);
   assign cnt_inc = sat ? cnt_q : cnt_q + CNT_ONE;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         high_r_q  <= '0;
         period_o  <= '0;
         high_o    <= '0;
         valid_o   <= 1'b0;
         timeout_o <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         high_r_q  <= high_r_d;
         period_o  <= period_d;
         high_o    <= high_d;
         valid_o   <= valid_d;
         timeout_o <= timeout_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      high_r_d  = high_r_q;
      period_d  = period_o;
      high_d    = high_o;
      valid_d   = 1'b0;
      timeout_d = timeout_o;

      if (!enable_i) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               cnt_d = '0;
               if (rise) begin
                  cnt_d   = CNT_ONE;
                  state_d = HIGH;
               end
            end
            HIGH: begin
               if (fall) begin
                  high_r_d = cnt_q;
                  cnt_d    = cnt_inc;
                  state_d  = LOW;
               end else if (sat) begin
                  timeout_d = 1'b1;
                  cnt_d     = '0;
                  state_d   = IDLE;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            LOW: begin
               // A rise landing on the saturation cycle still counts as a measurement.
               if (rise) begin
                  period_d  = cnt_q;
                  high_d    = high_r_q;
                  valid_d   = 1'b1;
                  timeout_d = 1'b0;
                  cnt_d     = CNT_ONE;
                  state_d   = HIGH;
               end else if (sat) begin
                  timeout_d = 1'b1;
                  cnt_d     = '0;
                  state_d   = IDLE;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - self-checking bench for pwm_capture
module tb_pwm_capture;

   localparam int LAT = 2;

   typedef struct {
      int h;
      int l;
      int reps;
      int ep;
      int eh;
   } row_t;

   typedef struct {
      int cyc;
      int p;
      int h;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        en16, pwm16, en8, pwm8;
   logic [15:0] p16, h16;
   logic        v16, t16, l16;
   logic [7:0]  p8, h8;
   logic        v8, t8, l8;

   int   cyc;
   int   n_checks;
   int   n_fail;
   bit   pend_valid;
   int   pend_p, pend_h;
   int   last_ep, last_eh;
   exp_t exp_q[$];
   row_t rows[5];

   always #5 clk = ~clk;

   pwm_capture u16 (
      .clk_i(clk), .rst_i(rst), .enable_i(en16), .pwm_i(pwm16),
      .period_o(p16), .high_o(h16), .valid_o(v16), .timeout_o(t16), .level_o(l16)
   );

   pwm_capture #(.CNT_BITS(8), .SYNC_STAGES(2)) u8 (
      .clk_i(clk), .rst_i(rst), .enable_i(en8), .pwm_i(pwm8),
      .period_o(p8), .high_o(h8), .valid_o(v8), .timeout_o(t8), .level_o(l8)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
      end
   endtask

   task automatic monitor16();
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
         check("valid16_strobe", v16, 1);
         check("period16", p16, exp_q[0].p);
         check("high16", h16, exp_q[0].h);
         check("timeout16_at_strobe", t16, 0);
         void'(exp_q.pop_front());
      end else begin
         check("valid16_quiet", v16, 0);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      monitor16();
   endtask

   task automatic run_to(input int target);
      while (cyc < target) tick();
   endtask

   // Start a high phase on u16; the period that just closed is reported LAT edges later.
   task automatic rise16();
      int e;
      pwm16 = 1'b1;
      e = cyc + 1;
      if (pend_valid) begin
         exp_q.push_back('{e + LAT, pend_p, pend_h});
         last_ep = pend_p;
         last_eh = pend_h;
      end
      pend_valid = 1'b0;
   endtask

   task automatic drive_period(input int h, input int l, input int ep, input int eh);
      rise16();
      repeat (h) tick();
      pwm16 = 1'b0;
      repeat (l) tick();
      pend_valid = 1'b1;
      pend_p     = ep;
      pend_h     = eh;
   endtask

   initial begin
      int e1, e2, e3, e4;
      int h, l;

      rows[0] = '{30, 70, 3, 100, 30};
      rows[1] = '{25, 75, 5, 100, 25};
      rows[2] = '{80, 20, 3, 100, 80};
      rows[3] = '{1, 1, 4, 2, 1};
      rows[4] = '{1, 50, 3, 51, 1};

      n_checks = 0; n_fail = 0; cyc = 0;
      pend_valid = 1'b0; pend_p = 0; pend_h = 0; last_ep = 0; last_eh = 0;
      rst = 1'b1; en16 = 1'b1; pwm16 = 1'b0; en8 = 1'b1; pwm8 = 1'b0;
      repeat (3) tick();
      check("rst_period16", p16, 0);
      check("rst_high16", h16, 0);
      check("rst_timeout16", t16, 0);
      check("rst_level16", l16, 0);
      check("rst_period8", p8, 0);
      check("rst_valid8", v8, 0);
      check("rst_timeout8", t8, 0);
      rst = 1'b0;
      repeat (3) tick();

      for (int r = 0; r < 5; r++)
         for (int k = 0; k < rows[r].reps; k++)
            drive_period(rows[r].h, rows[r].l, rows[r].ep, rows[r].eh);

      for (int i = 0; i < 20; i++) begin
         h = $urandom_range(1, 40);
         l = $urandom_range(1, 40);
         drive_period(h, l, h + l, h);
      end

      rise16();
      repeat (10) tick();
      en16 = 1'b0;
      repeat (10) tick();
      check("dis_hold_period16", p16, last_ep);
      check("dis_hold_high16", h16, last_eh);
      check("dis_hold_timeout16", t16, 0);
      pwm16 = 1'b0;
      repeat (30) tick();
      en16 = 1'b1;
      repeat (20) tick();
      check("reen_hold_period16", p16, last_ep);
      drive_period(15, 25, 40, 15);
      drive_period(10, 30, 40, 10);

      rise16();
      repeat (12) tick();
      pwm16 = 1'b0;
      repeat (10) tick();
      rst = 1'b1;
      #1;
      check("midrst_period16", p16, 0);
      check("midrst_high16", h16, 0);
      check("midrst_valid16", v16, 0);
      check("midrst_timeout16", t16, 0);
      check("midrst_level16", l16, 0);
      repeat (2) tick();
      rst = 1'b0;
      repeat (10) tick();
      drive_period(20, 20, 40, 20);
      drive_period(20, 20, 40, 20);
      rise16();
      repeat (6) tick();
      en16 = 1'b0;
      pwm16 = 1'b0;
      repeat (4) tick();

      pwm8 = 1'b1;
      run_to(cyc + 10);
      pwm8 = 1'b0;
      run_to(cyc + 10);
      pwm8 = 1'b1;
      e1 = cyc + 1;
      run_to(e1 + LAT - 1);
      check("u8_pre_strobe", v8, 0);
      run_to(e1 + LAT);
      check("u8_valid", v8, 1);
      check("u8_period", p8, 20);
      check("u8_high", h8, 10);
      run_to(e1 + 9);
      pwm8 = 1'b0;
      run_to(e1 + LAT + 254);
      check("u8_lo_timeout_early", t8, 0);
      tick();
      check("u8_lo_timeout", t8, 1);
      check("u8_lo_level", l8, 0);
      check("u8_lo_hold_period", p8, 20);
      check("u8_lo_hold_high", h8, 10);

      run_to(cyc + 5);
      pwm8 = 1'b1;
      e2 = cyc + 1;
      run_to(e2 + LAT);
      check("u8_restart_novalid", v8, 0);
      check("u8_restart_timeout_sticky", t8, 1);
      run_to(e2 + 9);
      pwm8 = 1'b0;
      run_to(e2 + 19);
      pwm8 = 1'b1;
      e3 = cyc + 1;
      run_to(e3 + LAT - 1);
      check("u8_rec_timeout_before", t8, 1);
      tick();
      check("u8_rec_valid", v8, 1);
      check("u8_rec_period", p8, 20);
      check("u8_rec_timeout_clear", t8, 0);

      run_to(e3 + 99);
      pwm8 = 1'b0;
      run_to(e3 + 254);
      pwm8 = 1'b1;
      e4 = cyc + 1;
      run_to(e4 + LAT);
      check("u8_sat_valid", v8, 1);
      check("u8_sat_period", p8, 255);
      check("u8_sat_high", h8, 100);
      check("u8_sat_timeout", t8, 0);
      tick();
      check("u8_sat_timeout_after", t8, 0);
      run_to(e4 + LAT + 254);
      check("u8_hi_timeout_early", t8, 0);
      tick();
      check("u8_hi_timeout", t8, 1);
      check("u8_hi_level", l8, 1);
      check("u8_hi_hold_period", p8, 255);
      check("u8_hi_hold_high", h8, 100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
